// File: rtl/serial_tag_receiver.sv
// Receives MSB-first tags from an asynchronous gated serial link and buffers
// them in a small FIFO for a ready/valid consumer.
module serial_tag_receiver #(
  parameter int WORD_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        serial_clk,
  input  logic                        serial_out,
  input  logic                        serial_valid,
  output logic [WORD_W-1:0]           tag_data,
  output logic                        tag_valid,
  input  logic                        tag_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clear_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WORD_W + 2);
  localparam logic [BIT_W-1:0] BITS_FULL = BIT_W'(WORD_W);
  localparam logic [BIT_W-1:0] BITS_SAT  = BIT_W'(WORD_W + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic [SYNC_STAGES-1:0] r_sval_sync;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_sclk_d;
  logic                   r_sval_d;
  logic                   r_armed;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [BIT_W-1:0]       r_bits;
  logic [BIT_W-1:0]       w_bits_nxt;
  logic [WORD_W-1:0]      r_shift;
  logic [WORD_W-1:0]      w_shift_nxt;
  logic                   w_push;
  logic                   w_ferr_set;

  logic [WORD_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr;
  logic [PTR_W-1:0]       r_rd;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   r_tag_valid;
  logic                   r_overflow;
  logic                   r_frame_err;

  logic w_sclk_s;
  logic w_sdat_s;
  logic w_sval_s;
  logic w_sclk_fall;
  logic w_sval_fall;
  logic w_sval_rise;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_ovf_set;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdat_s    = r_sdat_sync[SYNC_STAGES-1];
  assign w_sval_s    = r_sval_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_sval_rise = ~r_sval_d & w_sval_s;
  // A frame start only counts once the link has been seen idle on real samples,
  // so a frame cut by reset is skipped rather than picked up half-way.
  assign w_sval_fall = r_armed & r_sval_d & ~w_sval_s;

  // Input synchronizers, edge-detect copies and the post-reset arming flag.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_sdat_sync <= {SYNC_STAGES{1'b0}};
      r_sval_sync <= {SYNC_STAGES{1'b1}};
      r_fill      <= {(SYNC_STAGES + 1){1'b0}};
      r_sclk_d    <= 1'b0;
      r_sval_d    <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync[0] <= serial_clk;
      r_sdat_sync[0] <= serial_out;
      r_sval_sync[0] <= serial_valid;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_sdat_sync[i] <= r_sdat_sync[i-1];
        r_sval_sync[i] <= r_sval_sync[i-1];
      end
      r_fill[0] <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        r_fill[i] <= r_fill[i-1];
      end
      r_sclk_d <= w_sclk_s;
      r_sval_d <= w_sval_s;
      if (r_fill[SYNC_STAGES] && r_sval_d) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Receive FSM state, bit counter and shift register.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bits  <= {BIT_W{1'b0}};
      r_shift <= {WORD_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_bits  <= w_bits_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic; a bit edge in the same cycle as frame end is counted first.
  always_comb begin
    w_state_nxt = r_state;
    w_bits_nxt  = r_bits;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sval_fall) begin
          w_state_nxt = ST_SHIFT;
          w_bits_nxt  = {BIT_W{1'b0}};
          w_shift_nxt = {WORD_W{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_sclk_fall) begin
          w_shift_nxt = {r_shift[WORD_W-2:0], w_sdat_s};
          if (r_bits != BITS_SAT) begin
            w_bits_nxt = r_bits + BIT_W'(1);
          end else begin
            w_bits_nxt = r_bits;
          end
        end else begin
          w_shift_nxt = r_shift;
        end
        if (w_sval_rise) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_CHECK: begin
        if (r_bits == BITS_FULL) begin
          w_push = 1'b1;
        end else begin
          w_ferr_set = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_pop     = r_tag_valid & tag_ready;
  assign w_full    = (r_count == DEPTH_C);
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // Occupancy update: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // FIFO storage, pointers, occupancy and sticky error flags.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {WORD_W{1'b0}};
      end
      r_wr        <= {PTR_W{1'b0}};
      r_rd        <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_tag_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_tag_valid <= (w_count_nxt != {CNT_W{1'b0}});
      r_overflow  <= w_ovf_set  | (r_overflow  & ~clear_flags);
      r_frame_err <= w_ferr_set | (r_frame_err & ~clear_flags);
    end
  end

  assign tag_data   = r_mem[r_rd];
  assign tag_valid  = r_tag_valid;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_serial_tag_receiver.sv
// Scoreboard bench for serial_tag_receiver: directed link scenarios plus random
// frames, with a monitor popping expected tags whenever the consumer accepts one.
module tb_serial_tag_receiver;
  localparam int WORD_W      = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic        sys_clk      = 1'b0;
  logic        rst          = 1'b0;
  logic        serial_clk   = 1'b0;
  logic        serial_out   = 1'b0;
  logic        serial_valid = 1'b1;
  logic        tag_ready    = 1'b0;
  logic        clear_flags  = 1'b0;
  logic [15:0] tag_data;
  logic        tag_valid;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        frame_err;

  int          n_checks     = 0;
  int          n_fail       = 0;
  int          ready_mode   = 0;
  int          valid_cycles = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [31:0] w;
  int          n;
  int          v0;
  logic        bad;
  logic        ovf_exp;

  serial_tag_receiver #(
    .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .serial_clk(serial_clk), .serial_out(serial_out),
    .serial_valid(serial_valid), .tag_data(tag_data), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .fifo_count(fifo_count), .overflow(overflow),
    .frame_err(frame_err), .clear_flags(clear_flags)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #2;
    case (ready_mode)
      0:       tag_ready = 1'b0;
      1:       tag_ready = 1'b1;
      default: tag_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge sys_clk) begin
    if (tag_valid) valid_cycles++;
    if (tag_valid && tag_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %h, none expected", tag_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tag_data !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data: got %h expected %h", tag_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sample;
    @(negedge sys_clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] word, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      serial_out = word[i];
      serial_clk = 1'b1;
      repeat (HALF) tick();
      serial_clk = 1'b0;
      repeat (HALF) tick();
    end
  endtask

  task automatic frame_start;
    serial_valid = 1'b0;
    repeat (5) tick();
  endtask

  // pulse 1: consumer accepts exactly in the frame check cycle; pulse 2: clear_flags there.
  task automatic frame_end(input int pulse);
    repeat (5) tick();
    serial_valid = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    if (pulse == 1) ready_mode = 1;
    if (pulse == 2) clear_flags = 1'b1;
    tick();
    if (pulse == 1) ready_mode = 0;
    clear_flags = 1'b0;
    repeat (10) tick();
  endtask

  task automatic send_frame(input logic [31:0] word, input int nb, input int pulse);
    frame_start();
    send_bits(word, nb);
    frame_end(pulse);
  endtask

  task automatic pulse_clear;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    tick();
  endtask

  task automatic drain;
    ready_mode = 1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    ready_mode = 0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tag_valid"}, 32'(tag_valid), 32'd0);
    chk({tag, "_tag_data"}, 32'(tag_data), 32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    sample();
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) tick();

    // single frame, consumer always ready
    ready_mode = 1;
    v0 = valid_cycles;
    exp_q.push_back(16'hA5C3);
    send_frame(32'h0000A5C3, 16, 0);
    sample();
    chk("a5c3_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    chk("a5c3_count", 32'(fifo_count), 32'd0);
    chk("a5c3_delivered", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // five frames into a four-deep FIFO with no consumer
    ovf_exp = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(16'(k));
      else ovf_exp = 1'b1;
      send_frame(32'(k), 16, 0);
    end
    sample();
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_overflow", 32'(overflow), 32'(ovf_exp));
    drain();
    sample();
    chk("fill_drained_count", 32'(fifo_count), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    sample();
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // short frame followed by a good one
    ready_mode = 1;
    send_frame(32'($urandom), 15, 0);
    exp_q.push_back(16'h1234);
    send_frame(32'h00001234, 16, 0);
    sample();
    chk("short_frame_err", 32'(frame_err), 32'd1);
    chk("short_only_good", 32'(exp_q.size()), 32'd0);
    chk("short_count", 32'(fifo_count), 32'd0);
    pulse_clear();
    sample();
    chk("short_err_cleared", 32'(frame_err), 32'd0);
    ready_mode = 0;

    // long frame; clear_flags lands in the same cycle as the error
    w = $urandom;
    exp_q.push_back(w[15:0]);
    send_frame(w, 16, 0);
    send_frame(32'($urandom), 17, 2);
    sample();
    chk("long_count", 32'(fifo_count), 32'd1);
    chk("long_err_set_wins", 32'(frame_err), 32'd1);
    pulse_clear();
    sample();
    chk("long_err_cleared", 32'(frame_err), 32'd0);
    drain();

    // full FIFO, consumer accepts in the same cycle as a new push
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w = $urandom;
      exp_q.push_back(w[15:0]);
      send_frame(w, 16, 0);
    end
    exp_q.push_back(16'hBEEF);
    send_frame(32'h0000BEEF, 16, 1);
    sample();
    chk("full_pushpop_count", 32'(fifo_count), 32'd4);
    chk("full_pushpop_overflow", 32'(overflow), 32'd0);
    drain();

    // random frame lengths and random consumer readiness
    ready_mode = 2;
    bad = 1'b0;
    for (int r = 0; r < 10; r++) begin
      n = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
      w = $urandom;
      if (n == 16) exp_q.push_back(w[15:0]);
      else bad = 1'b1;
      send_frame(w, n, 0);
      sample();
      chk("rand_frame_err", 32'(frame_err), 32'(bad));
    end
    drain();
    sample();
    chk("rand_overflow", 32'(overflow), 32'd0);
    chk("rand_count", 32'(fifo_count), 32'd0);
    pulse_clear();

    // reset in the middle of a frame
    w = $urandom;
    exp_q.push_back(w[15:0]);
    send_frame(w, 16, 0);
    send_frame(32'($urandom), 15, 0);
    sample();
    chk("prereset_count", 32'(fifo_count), 32'd1);
    chk("prereset_err", 32'(frame_err), 32'd1);
    frame_start();
    send_bits(32'h0000005A, 8);
    rst = 1'b0;
    repeat (2) tick();
    sample();
    chk_reset_outputs("midreset");
    exp_q.delete();
    rst = 1'b1;
    send_bits(32'h0000005A, 8);
    frame_end(0);
    sample();
    chk("tail_ignored_count", 32'(fifo_count), 32'd0);
    chk("tail_ignored_err", 32'(frame_err), 32'd0);
    ready_mode = 1;
    exp_q.push_back(16'h00FF);
    send_frame(32'h000000FF, 16, 0);
    sample();
    chk("after_reset_delivered", 32'(exp_q.size()), 32'd0);
    chk("after_reset_count", 32'(fifo_count), 32'd0);
    chk("after_reset_err", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tag_receiver.md
SERIAL_TAG_RECEIVER -- requirements
Module: serial_tag_receiver

Interface
REQ-001 Parameter WORD_W, default 16, bits per phase-tag frame.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, words buffered.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per serial input.
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous reset, active-low (rst=0 resets on next sys_clk edge).
REQ-006 serial_clk  in  1  async link clock; gated, toggles only inside a frame.
REQ-007 serial_out  in  1  async link data, MSB first, changes on serial_clk rising edge.
REQ-008 serial_valid  in  1  async link idle flag; 0 = frame in progress, 1 = idle.
REQ-009 tag_data  out  WORD_W  head-of-FIFO tag.
REQ-010 tag_valid  out  1  FIFO non-empty.
REQ-011 tag_ready  in  1  consumer accepts tag_data when tag_valid=1.
REQ-012 fifo_count  out  $clog2(FIFO_DEPTH)+1  words held.
REQ-013 overflow  out  1  sticky: completed frame dropped, FIFO full.
REQ-014 frame_err  out  1  sticky: frame with bit count != WORD_W.
REQ-015 clear_flags  in  1  single-cycle pulse clearing overflow and frame_err.

Function
REQ-016 serial_clk, serial_out, serial_valid each pass SYNC_STAGES flops before use; no other logic touches raw inputs.
REQ-017 Edge detect on synchronized signals via one extra registered copy; events valid one sys_clk after synchronizer output.
REQ-018 Data bit sampled on synchronized serial_clk falling edge (1->0); shifted into LSB of WORD_W shift register, prior bits move toward MSB.
REQ-019 Receive FSM states: IDLE, SHIFT, CHECK.
REQ-020 IDLE -> SHIFT on synchronized serial_valid falling edge; bit counter and shift register cleared.
REQ-021 SHIFT: each serial_clk falling edge increments bit counter; counter saturates at WORD_W+1.
REQ-022 SHIFT -> CHECK on synchronized serial_valid rising edge; if clock falling edge and serial_valid rising edge occur same cycle, bit counted first.
REQ-023 CHECK (one cycle): count == WORD_W -> push shift register; otherwise set frame_err, discard; then -> IDLE.
REQ-024 Push while fifo_count == FIFO_DEPTH: word discarded, overflow set, FIFO contents unchanged.
REQ-025 Pop when tag_valid && tag_ready; tag_data advances next cycle.
REQ-026 Simultaneous push and pop when full: pop first, push accepted, fifo_count unchanged, no overflow.
REQ-027 Simultaneous push and pop when empty: push only, tag_valid=1 next cycle.
REQ-028 Push-to-tag_valid latency: 1 sys_clk after CHECK.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
REQ-030 clear_flags same cycle as new error: set wins, flag stays 1.
REQ-031 tag_data and fifo_count registered or FIFO-memory driven; no combinational path from serial inputs.
REQ-032 Requirement on source: serial_clk period >= 2*(SYNC_STAGES+2) sys_clk periods; faster links are out of scope and undetected.

Reset
REQ-033 rst=0: FSM IDLE, bit counter 0, shift register 0, FIFO pointers 0, fifo_count 0, tag_valid 0, tag_data 0, overflow 0, frame_err 0.
REQ-034 Synchronizer flops reset to idle values: serial_clk 0, serial_out 0, serial_valid 1.
REQ-035 Reset mid-frame abandons partial word; after release, remainder of that frame ignored until serial_valid seen 1 then falls.

Verification
REQ-036 Frame 0xA5C3, serial_clk = sys_clk/10, tag_ready=1 -> tag_data=0xA5C3, tag_valid one cycle, fifo_count back to 0.
REQ-037 Five frames 0x0001..0x0005, tag_ready=0 -> fifo_count=4, overflow=1, pops return 0x0001..0x0004 in order.
REQ-038 Frame of 15 bits then valid 16-bit frame 0x1234 -> frame_err=1, only 0x1234 pushed; clear_flags pulse -> frame_err=0.
REQ-039 17-bit frame -> frame_err=1, fifo_count unchanged.
REQ-040 FIFO full, tag_ready=1 during push of 0xBEEF -> no overflow, fifo_count stays 4, 0xBEEF last out.
REQ-041 rst=0 after 8 bits of a frame -> all outputs at reset values; next complete frame 0x00FF received correctly.
